// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, Status reset value
// and the software-writable bit masks of Status and Cause.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match raises TI until the
// next Compare write. Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_we_i,
  input  logic             compare_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] compare_o,
  output logic             ti_o
);

  localparam logic [3:0] PRE_LAST = 4'(COUNT_DIV - 1);

  logic [3:0]       pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic             ti_q, ti_d;

  always_comb begin
    pre_d     = pre_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      pre_d   = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      count_d = count_q + WIDTH'(1);
    end else begin
      pre_d = pre_q + 4'd1;
    end
    // A Compare write clears TI even if the match coincides with it.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: Status, Cause, EPC, BadVAddr and optional
// Count/Compare timer (enabled by defining CP0_TIMER_EN).
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned HW_INT_NUM = 6,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [WIDTH-1:0]      mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [WIDTH-1:0]      mfc0_rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [WIDTH-1:0]      exc_pc,
  input  logic                  exc_bd,
  input  logic [WIDTH-1:0]      exc_badvaddr,
  input  logic                  eret,
  output logic [WIDTH-1:0]      epc_out,
  output logic                  int_pending,
  output logic                  exl_out,
  output logic                  timer_int
);

  // Out-of-range configurations elaborate to an empty marker block.
  if (COUNT_DIV < 1 || COUNT_DIV > 16 || HW_INT_NUM < 1 || HW_INT_NUM > 6) begin : g_bad_cfg
  end

  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic [1:0]       sw_ip_q, sw_ip_d;
  logic [5:0]       hw_ip_q, hw_ext;
  logic             bd_q, bd_d;
  logic [4:0]       code_q, code_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] bva_q, bva_d;

  logic [WIDTH-1:0] count, compare;
  logic             ti;
  logic [7:0]       ip;
  logic             wr_status, wr_cause, wr_epc;

  if (HW_INT_NUM == 6) begin : g_hw_full
    assign hw_ext = hw_int;
  end else begin : g_hw_pad
    assign hw_ext = {{(6 - HW_INT_NUM){1'b0}}, hw_int};
  end

`ifdef CP0_TIMER_EN
  cp0_timer #(
    .WIDTH     (WIDTH),
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (mtc0_we && (mtc0_addr == REG_COUNT)),
    .compare_we_i (mtc0_we && (mtc0_addr == REG_COMPARE)),
    .wdata_i      (mtc0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  assign wr_status = mtc0_we && (mtc0_addr == REG_STATUS);
  assign wr_cause  = mtc0_we && (mtc0_addr == REG_CAUSE);
  assign wr_epc    = mtc0_we && (mtc0_addr == REG_EPC);

  assign ip = {hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q};

  // Later assignments win: exc_valid > eret > mtc0 on shared fields.
  always_comb begin
    im_d    = im_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    sw_ip_d = sw_ip_q;
    bd_d    = bd_q;
    code_d  = code_q;
    epc_d   = epc_q;
    bva_d   = bva_q;
    if (wr_status) begin
      im_d  = mtc0_wdata[15:8];
      exl_d = mtc0_wdata[1];
      ie_d  = mtc0_wdata[0];
    end
    if (wr_cause) sw_ip_d = mtc0_wdata[9:8];
    if (wr_epc)   epc_d   = mtc0_wdata;
    if (eret)     exl_d   = 1'b0;
    if (exc_valid) begin
      code_d = exc_code;
      epc_d  = epc_q;
      if (!exl_q) begin
        epc_d = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
        bd_d  = exc_bd;
        exl_d = 1'b1;
      end
      if (is_addr_exc(exc_code)) bva_d = exc_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q    <= '0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b0;
      sw_ip_q <= '0;
      hw_ip_q <= '0;
      bd_q    <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      bva_q   <= '0;
    end else begin
      im_q    <= im_d;
      exl_q   <= exl_d;
      ie_q    <= ie_d;
      sw_ip_q <= sw_ip_d;
      hw_ip_q <= hw_ext;
      bd_q    <= bd_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      bva_q   <= bva_d;
    end
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      REG_BADVADDR: mfc0_rdata = bva_q;
      REG_COUNT:    mfc0_rdata = count;
      REG_COMPARE:  mfc0_rdata = compare;
      REG_STATUS:   mfc0_rdata = WIDTH'(STATUS_RESET |
                                 ({16'h0, im_q, 6'h0, exl_q, ie_q} & STATUS_WMASK));
      REG_CAUSE:    mfc0_rdata = WIDTH'({bd_q, ti, 14'h0, 8'h0, 1'b0, code_q, 2'b0} |
                                 ({16'h0, ip, 8'h0} & 32'h0000_FC00) |
                                 ({16'h0, ip, 8'h0} & CAUSE_WMASK));
      REG_EPC:      mfc0_rdata = epc_q;
      default:      mfc0_rdata = '0;
    endcase
  end

  assign epc_out     = epc_q;
  assign exl_out     = exl_q;
  assign timer_int   = ti;
  assign int_pending = ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit; expectations go through a scoreboard queue.
// Timer expectations follow CP0_TIMER_EN as defined for the compile.
module tb_cp0_exc_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   hw_int;
  logic         mtc0_we;
  logic [4:0]   mtc0_addr, mfc0_addr, exc_code;
  logic [W-1:0] mtc0_wdata, mfc0_rdata, exc_pc, exc_badvaddr, epc_out;
  logic         exc_valid, exc_bd, eret;
  logic         int_pending, exl_out, timer_int;

  cp0_exc_unit #(.WIDTH(32), .HW_INT_NUM(6), .COUNT_DIV(2)) dut (
    .clk(clk), .rst(rst), .hw_int(hw_int),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .epc_out(epc_out), .int_pending(int_pending), .exl_out(exl_out),
    .timer_int(timer_int)
  );

  always #10 clk = ~clk;

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t        sb[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_total++;
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.exp);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] mask,
                    input logic [31:0] exp, input string tag);
    push_exp(tag, exp & mask);
    mfc0_addr = a;
    #1;
    check(mfc0_rdata & mask);
  endtask

  task automatic bit_chk(input string tag, input logic exp, input logic obs);
    push_exp(tag, {31'h0, exp});
    check({31'h0, obs});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
    tick();
    mtc0_we = 1'b0;
  endtask

  task automatic set_exc(input logic [4:0] c, input logic [31:0] pc,
                         input logic bd, input logic [31:0] bva);
    exc_valid = 1'b1; exc_code = c; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
  endtask

  task automatic do_exc(input logic [4:0] c, input logic [31:0] pc,
                        input logic bd, input logic [31:0] bva);
    set_exc(c, pc, bd, bva);
    tick();
    exc_valid = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst = 1'b1; hw_int = '0; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0;
    mfc0_addr = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr = '0; eret = 1'b0;
    tick(2);
    // reset must override commits and writes in the same cycle
    set_exc(5'd4, 32'h0000_1000, 1'b0, 32'h77);
    eret = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'hFFFF_FFFF;
    tick();
    exc_valid = 1'b0; eret = 1'b0; mtc0_we = 1'b0; rst = 1'b0;

    rd(5'd12, 32'hFFFF_FFFF, 32'h0040_0000, "status_rst");
    rd(5'd13, 32'hFFFF_FFFF, 32'h0, "cause_rst");
    rd(5'd14, 32'hFFFF_FFFF, 32'h0, "epc_rst");
    rd(5'd8,  32'hFFFF_FFFF, 32'h0, "badvaddr_rst");
    rd(5'd9,  32'hFFFF_FFFF, 32'h0, "count_rst");
    rd(5'd11, 32'hFFFF_FFFF, 32'h0, "compare_rst");
    rd(5'd5,  32'hFFFF_FFFF, 32'h0, "unimpl_reg");
    bit_chk("int_pending_rst", 1'b0, int_pending);
    bit_chk("exl_rst", 1'b0, exl_out);
    bit_chk("ti_rst", 1'b0, timer_int);

    tick(10);
`ifdef CP0_TIMER_EN
    rd(5'd9, 32'hFFFF_FFFF, 32'd5, "count_10cyc");
    wr(5'd9, 32'd0);
    wr(5'd11, 32'd8);
    wr(5'd12, 32'h0000_8001);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mfc0_addr = 5'd9;
      #1;
      if (mfc0_rdata == 32'd8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    bit_chk("count_reach8", 1'b1, found);
    bit_chk("ti_at_match", 1'b0, timer_int);
    tick();
    bit_chk("ti_set", 1'b1, timer_int);
    rd(5'd13, 32'h4000_8000, 32'h4000_8000, "cause_ti_ip7");
    bit_chk("int_timer", 1'b1, int_pending);
    wr(5'd11, 32'd100);
    bit_chk("ti_clr", 1'b0, timer_int);
    bit_chk("int_timer_clr", 1'b0, int_pending);
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "count_load");
    tick();
    rd(5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "count_hold");
    tick();
    rd(5'd9, 32'hFFFF_FFFF, 32'h0, "count_wrap");
`else
    rd(5'd9, 32'hFFFF_FFFF, 32'd0, "count_10cyc");
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd11, 32'd8);
    rd(5'd9, 32'hFFFF_FFFF, 32'h0, "count_nowr");
    rd(5'd11, 32'hFFFF_FFFF, 32'h0, "compare_nowr");
    tick(20);
    rd(5'd9, 32'hFFFF_FFFF, 32'h0, "count_stays0");
    bit_chk("ti_off", 1'b0, timer_int);
`endif
    wr(5'd12, 32'h0);

    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'hFFFF_FFFF, 32'h0040_FF03, "status_wmask");
    bit_chk("exl_by_mtc0", 1'b1, exl_out);
    wr(5'd12, 32'h0000_0101);
    bit_chk("swint_off", 1'b0, int_pending);
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h8000_037C, 32'h0000_0300, "cause_wmask");
    bit_chk("swint_on", 1'b1, int_pending);
    wr(5'd13, 32'h0);
    bit_chk("swint_clr", 1'b0, int_pending);
    wr(5'd12, 32'h0);
    wr(5'd14, 32'h1234_5678);
    rd(5'd14, 32'hFFFF_FFFF, 32'h1234_5678, "epc_mtc0");

    do_exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h1);
    rd(5'd14, 32'hFFFF_FFFF, 32'hBFC0_00FC, "epc_bd");
    rd(5'd13, 32'h8000_007C, 32'h8000_0010, "cause_adel");
    rd(5'd8,  32'hFFFF_FFFF, 32'h1, "badvaddr_adel");
    rd(5'd12, 32'hFFFF_FFFF, 32'h0040_0002, "status_exl");
    bit_chk("exl_exc", 1'b1, exl_out);
    do_exc(5'd8, 32'h0000_0100, 1'b0, 32'h55);
    rd(5'd14, 32'hFFFF_FFFF, 32'hBFC0_00FC, "epc_hold");
    rd(5'd13, 32'h8000_007C, 32'h8000_0020, "cause_nested");
    rd(5'd8,  32'hFFFF_FFFF, 32'h1, "badvaddr_hold");

    set_exc(5'd9, 32'h0000_0200, 1'b0, 32'h0);
    mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_wdata = 32'h1234;
    tick();
    exc_valid = 1'b0; mtc0_we = 1'b0;
`ifdef CP0_TIMER_EN
    rd(5'd11, 32'hFFFF_FFFF, 32'h1234, "compare_vs_exc");
`else
    rd(5'd11, 32'hFFFF_FFFF, 32'h0, "compare_vs_exc");
`endif
    rd(5'd14, 32'hFFFF_FFFF, 32'hBFC0_00FC, "epc_hold_mtc0");

    do_eret();
    bit_chk("exl_eret", 1'b0, exl_out);
    push_exp("epc_eret", 32'hBFC0_00FC);
    check(epc_out);

    set_exc(5'd0, 32'h8000_0200, 1'b0, 32'h0);
    eret = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0;
    tick();
    exc_valid = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
    bit_chk("prio_exl", 1'b1, exl_out);
    push_exp("prio_epc", 32'h8000_0200);
    check(epc_out);
    rd(5'd13, 32'h8000_007C, 32'h0, "prio_cause");
    do_eret();

    do_exc(5'd5, 32'h0000_0300, 1'b0, 32'hDEAD_0000);
    rd(5'd8, 32'hFFFF_FFFF, 32'hDEAD_0000, "badvaddr_ades");
    rd(5'd14, 32'hFFFF_FFFF, 32'h0000_0300, "epc_ades");
    do_eret();

    wr(5'd12, 32'h0000_1001);
    hw_int = 6'b000100;
    #1;
    bit_chk("hwint_lat0", 1'b0, int_pending);
    tick();
    bit_chk("hwint", 1'b1, int_pending);
    rd(5'd13, 32'h0000_FC00, 32'h0000_1000, "cause_ip4");
    do_exc(5'd0, 32'h0000_0400, 1'b0, 32'h0);
    bit_chk("hwint_exl", 1'b0, int_pending);
    do_eret();
    bit_chk("hwint_eret", 1'b1, int_pending);
    hw_int = 6'b000000;
    tick();
    bit_chk("hwint_drop", 1'b0, int_pending);
    hw_int = 6'b100000;
    tick();
    rd(5'd13, 32'h0000_8000, 32'h0000_8000, "cause_ip7_hw");
    hw_int = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of every CP0 register.
REQ-002 SHALL have parameter HW_INT_NUM, default 6, range 1..6: number of hardware interrupt lines, mapped to Cause.IP[2+HW_INT_NUM-1:2].
REQ-003 SHALL have parameter COUNT_DIV, default 2, range 1..16: clock cycles per Count increment.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: hw_int  in  HW_INT_NUM  level interrupt requests, sampled every cycle.
REQ-006 mtc0_we  in  1  register write strobe; mtc0_addr  in  5  write register number; mtc0_wdata  in  WIDTH  write data.
REQ-007 mfc0_addr  in  5  read register number; mfc0_rdata  out  WIDTH  combinational read data, 0 for unimplemented numbers.
REQ-008 exc_valid  in  1  exception commit; exc_code  in  5  ExcCode; exc_pc  in  WIDTH  faulting PC; exc_bd  in  1  faulting instr in delay slot; exc_badvaddr  in  WIDTH  faulting address.
REQ-009 eret  in  1  ERET commit; epc_out  out  WIDTH  EPC register; int_pending  out  1  interrupt to take; exl_out  out  1  Status.EXL; timer_int  out  1  Cause.TI.

Function
REQ-010 Implemented registers SHALL be BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
REQ-011 Writable fields SHALL be: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; Count, Compare, EPC full width; all other bits read back at reset value; BadVAddr not writable by mtc0.
REQ-012 A prescaler SHALL increment Count by 1 (mod 2^WIDTH, wraps to 0) once every COUNT_DIV cycles; a Count write loads the value and restarts the prescaler.
REQ-013 Cause.TI (bit 30) SHALL set the cycle after Count==Compare and stay set until the next Compare write, which clears it in the same cycle the new value is loaded.
REQ-014 Cause.IP[7:2] SHALL register hw_int each cycle (one-cycle latency), unused lines 0; IP7 SHALL be hw_int[5] OR TI.
REQ-015 int_pending SHALL be combinational: Status.IE AND NOT Status.EXL AND OR(Cause.IP[7:0] AND Status.IM[7:0]).
REQ-016 On exc_valid with EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; Cause.BD <= exc_bd; Cause.ExcCode <= exc_code; EXL <= 1.
REQ-017 On exc_valid with EXL=1: only Cause.ExcCode updates; EPC and BD SHALL hold.
REQ-018 On exc_valid with exc_code 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr; other codes leave it unchanged.
REQ-019 On eret: EXL <= 0; EPC unchanged.
REQ-020 Same-cycle priority SHALL be exc_valid > eret > mtc0 for any shared field; a losing mtc0 to a non-shared field (e.g. Compare) still takes effect.
REQ-021 mfc0 of a register written in the same cycle SHALL return the old value (no bypass).

Reset
REQ-022 On rst: Status = 0x0040_0000 (BEV=1, IM=0, EXL=0, IE=0); Cause, EPC, BadVAddr, Count, Compare, prescaler = 0; TI = 0; int_pending = 0.
REQ-023 rst SHALL override exc_valid, eret and mtc0_we in the same cycle.

Configuration
REQ-024 Macro CP0_TIMER_EN: defined -> Count/Compare/TI per REQ-012..013; undefined -> Count and Compare read 0, writes ignored, TI constant 0, IP7 = hw_int[5] only.

Structure
REQ-025 Shared package cp0_pkg SHALL hold register numbers, ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12), Status reset value and writable-bit masks.
REQ-026 Count/Compare/prescaler/TI SHALL be a sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-027 Reset, then mfc0 12 -> 0x0040_0000; mfc0 9 after 10 cycles (COUNT_DIV=2) -> 5.
REQ-028 mtc0 11 <= 8, Count from 0 -> TI=1 one cycle after Count==8; with IE=1, IM7=1 -> int_pending=1; mtc0 11 <= 100 -> TI=0 next cycle.
REQ-029 exc_valid, code=4, pc=0xBFC0_0100, bd=1, badvaddr=0x1 -> EPC=0xBFC0_00FC, BD=1, ExcCode=4, BadVAddr=0x1, EXL=1; second exc code=8 -> EPC held, ExcCode=8.
REQ-030 exc_valid and eret and mtc0 12 <= 0 same cycle -> EXL=1, EPC updated.
REQ-031 hw_int[2]=1, IM4=1, IE=1, EXL=0 -> int_pending=1 one cycle later; set EXL via exception -> int_pending=0; eret -> 1 again.
REQ-032 Count written 0xFFFF_FFFF -> wraps to 0 after COUNT_DIV cycles; CP0_TIMER_EN undefined -> mfc0 9 always 0.
